// File: rtl/zigbee_pkg.sv
// Shared types and the 802.15.4 2.4 GHz symbol-to-chip map for the chip spreader.
package zigbee_pkg;

    localparam int CHIPS_PER_SYMBOL = 32;
    localparam int SYM_W            = 4;

    typedef logic [CHIPS_PER_SYMBOL-1:0] chip_seq_t;

    // Literal reads chip 0 first, so chip 0 is the MSB here; chip_lut returns bit n = chip n.
    localparam chip_seq_t SYM0_CHIPS = 32'b1101_1001_1100_0011_0101_0010_0010_1110;

    typedef enum logic {IDLE, SHIFT} state_t;

    function automatic chip_seq_t chip_lut(input logic [SYM_W-1:0] sym);
        chip_seq_t  seq;
        logic [4:0] src;
        seq = '0;
        for (int n = 0; n < CHIPS_PER_SYMBOL; n++) begin
            src    = 5'(n) - {sym[2:0], 2'b00};
            seq[n] = SYM0_CHIPS[~src] ^ (sym[3] & n[0]);
        end
        return seq;
    endfunction

endpackage

// File: rtl/zigbee_chip_timer.sv
// Chip-period divider and chip index counter; flags the first and last cycle of each chip.
module zigbee_chip_timer #(
    parameter int CHIP_DIV = 25,
    parameter int DIV_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       run,
    output logic       strobe,
    output logic       chip_end,
    output logic       last_chip,
    output logic [4:0] chip_idx
);

    logic [DIV_W-1:0] div_cnt;
    logic             div_end;

    assign div_end   = (div_cnt == DIV_W'(CHIP_DIV - 1));
    assign strobe    = run & (div_cnt == '0);
    assign chip_end  = run & div_end;
    assign last_chip = (chip_idx == 5'd31);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            chip_idx <= '0;
        end else if (clear) begin
            div_cnt  <= '0;
            chip_idx <= '0;
        end else if (run) begin
            if (div_end) begin
                div_cnt  <= '0;
                chip_idx <= chip_idx + 5'd1;
            end else begin
                div_cnt  <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/zigbee_chip_spreader.sv
// Pops 4-bit symbols from the TX FIFO and serialises each as its 32-chip PN sequence
// at the chip rate, with a one-deep prefetch so back-to-back symbols are gapless.
import zigbee_pkg::*;

module zigbee_chip_spreader #(
    parameter int CHIP_DIV = 25,
    parameter int DIV_W    = 5
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic       inEnable,
    input  logic       inFifoEmpty,
    input  logic [3:0] inFifoData,
    output logic       outFifoReadEnable,
    output logic       outChip,
    output logic       outChipStrobe,
    output logic       outChipIQ,
    output logic       outChipValid,
    output logic       outSymbolDone,
    output logic       outUnderrun
);

    state_t           state;
    chip_seq_t        chip_seq;
    logic [SYM_W-1:0] next_sym;
    logic             next_valid;
    logic             capture;
    logic             strobe, chip_end, last_chip;
    logic [4:0]       chip_idx;
    logic             in_shift, boundary, avail, load, fetch;
    logic [SYM_W-1:0] load_sym;

    assign in_shift = (state == SHIFT);
    assign boundary = chip_end & last_chip;
    // A symbol landing from the FIFO on the boundary cycle is used directly.
    assign avail    = next_valid | capture;
    assign load     = ((state == IDLE) & next_valid) | (boundary & avail);
    assign load_sym = next_valid ? next_sym : inFifoData;
    assign fetch    = ~next_valid & ~outFifoReadEnable & ~capture & ~inFifoEmpty & inEnable;

    zigbee_chip_timer #(.CHIP_DIV(CHIP_DIV), .DIV_W(DIV_W)) u_timer (
        .clk       (inClock),
        .rst       (inReset),
        .clear     (load),
        .run       (in_shift),
        .strobe    (strobe),
        .chip_end  (chip_end),
        .last_chip (last_chip),
        .chip_idx  (chip_idx)
    );

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            state             <= IDLE;
            chip_seq          <= '0;
            next_sym          <= '0;
            next_valid        <= 1'b0;
            capture           <= 1'b0;
            outFifoReadEnable <= 1'b0;
        end else begin
            outFifoReadEnable <= fetch;
            capture           <= outFifoReadEnable;
            if (capture) begin
                next_sym   <= inFifoData;
                next_valid <= 1'b1;
            end
            if (load) begin
                chip_seq   <= chip_lut(load_sym);
                next_valid <= 1'b0;
            end
            case (state)
                IDLE:    if (next_valid) state <= SHIFT;
                SHIFT:   if (boundary && !avail) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign outChipValid  = in_shift;
    assign outChip       = in_shift & chip_seq[chip_idx];
    assign outChipIQ     = in_shift & chip_idx[0];
    assign outChipStrobe = strobe;
    assign outSymbolDone = boundary;
    assign outUnderrun   = boundary & ~avail & inEnable;

endmodule

// File: tb/tb_zigbee_chip_spreader.sv
// Self-checking bench for zigbee_chip_spreader: FIFO model, chip-stream monitor, string-based chip model.
module tb_zigbee_chip_spreader;

    localparam int CHIP_DIV = 25;
    localparam int SYM_CYC  = 32 * CHIP_DIV;

    logic       inClock = 1'b0;
    logic       inReset = 1'b1;
    logic       inEnable = 1'b0;
    logic       inFifoEmpty = 1'b1;
    logic [3:0] inFifoData = 4'h0;
    logic       outFifoReadEnable, outChip, outChipStrobe, outChipIQ;
    logic       outChipValid, outSymbolDone, outUnderrun;

    zigbee_chip_spreader #(.CHIP_DIV(CHIP_DIV), .DIV_W(5)) dut (
        .inClock           (inClock),
        .inReset           (inReset),
        .inEnable          (inEnable),
        .inFifoEmpty       (inFifoEmpty),
        .inFifoData        (inFifoData),
        .outFifoReadEnable (outFifoReadEnable),
        .outChip           (outChip),
        .outChipStrobe     (outChipStrobe),
        .outChipIQ         (outChipIQ),
        .outChipValid      (outChipValid),
        .outSymbolDone     (outSymbolDone),
        .outUnderrun       (outUnderrun)
    );

    always #10 inClock = ~inClock;

    int   tests = 0, fails = 0;
    logic [3:0] fifo[$];
    logic [3:0] exp_syms[$];
    logic chips[$];
    logic iqs[$];
    logic pop_seen = 1'b0;
    logic held = 1'b0;
    int   cyc = 0, pop_cnt = 0, done_cnt = 0, under_cnt = 0, strobe_cnt = 0;
    int   valid_cnt = 0, gap_err = 0, hold_err = 0, last_strobe = -1;

    // FIFO: read data appears the cycle after the pop request
    always @(posedge inClock)
        if (pop_seen && fifo.size() > 0) inFifoData <= fifo.pop_front();

    always @(negedge inClock) begin
        cyc         <= cyc + 1;
        pop_seen    <= outFifoReadEnable;
        inFifoEmpty <= (fifo.size() == 0);
        if (outFifoReadEnable) pop_cnt   <= pop_cnt + 1;
        if (outSymbolDone)     done_cnt  <= done_cnt + 1;
        if (outUnderrun)       under_cnt <= under_cnt + 1;
        if (outChipValid)      valid_cnt <= valid_cnt + 1;
        if (outChipStrobe) begin
            strobe_cnt <= strobe_cnt + 1;
            chips.push_back(outChip);
            iqs.push_back(outChipIQ);
            held <= outChip;
            if (last_strobe >= 0 && cyc - last_strobe != CHIP_DIV) gap_err <= gap_err + 1;
            last_strobe <= cyc;
        end else if (outChipValid && outChip !== held) begin
            hold_err <= hold_err + 1;
        end
        if (!outChipValid) last_strobe <= -1;
    end

    function automatic logic model_chip(input logic [3:0] sym, input int n);
        string s;
        int    idx;
        logic  c;
        s   = "11011001110000110101001000101110";
        idx = (n - 4 * (int'(sym) % 8) + 64) % 32;
        c   = (s[idx] == "1");
        if (sym >= 4'd8 && n % 2 == 1) c = ~c;
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge inClock);
            k++;
        end
        repeat (3) @(negedge inClock);
        tests++;
        if (done_cnt < target) begin
            fails++;
            $display("FAIL %s timeout: symbols done %0d expected %0d", name, done_cnt, target);
        end
    endtask

    task automatic wait_strobes(input int target, input string name);
        int k;
        k = 0;
        while (strobe_cnt < target && k < 2 * SYM_CYC) begin
            @(negedge inClock);
            k++;
        end
        tests++;
        if (strobe_cnt < target) begin
            fails++;
            $display("FAIL %s timeout: strobes %0d expected %0d", name, strobe_cnt, target);
        end
    endtask

    task automatic check_stream(input string name, input int base);
        int bad, n;
        bad = 0;
        n   = exp_syms.size() * 32;
        check({name, " length"}, chips.size() - base, n);
        for (int i = 0; i < n && base + i < chips.size(); i++) begin
            if (chips[base + i] !== model_chip(exp_syms[i / 32], i % 32)) bad++;
            if (iqs[base + i] !== 1'(i % 2)) bad++;
        end
        check({name, " chip errors"}, bad, 0);
    endtask

    typedef struct {
        logic [3:0]  sym;
        logic [31:0] chips;
    } vec_t;

    vec_t tbl[5];
    int   b, d0, u0, p0, v0, g0, h0, s0;
    logic [31:0] got, got_iq;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // chip 0 in the MSB
        tbl[0] = '{4'h0, 32'hD9C3522E};
        tbl[1] = '{4'h1, 32'hED9C3522};
        tbl[2] = '{4'h2, 32'h2ED9C352};
        tbl[3] = '{4'h8, 32'h8C96077B};
        tbl[4] = '{4'h9, 32'hB8C96077};

        #5;
        check("reset outputs", {25'd0, outFifoReadEnable, outChip, outChipStrobe, outChipIQ,
                                outChipValid, outSymbolDone, outUnderrun}, 32'd0);
        repeat (3) @(negedge inClock);
        inReset = 1'b0;
        repeat (2) @(negedge inClock);

        for (int t = 0; t < 5; t++) begin
            b = chips.size(); d0 = done_cnt; u0 = under_cnt; p0 = pop_cnt; g0 = gap_err; h0 = hold_err;
            fifo.push_back(tbl[t].sym);
            @(negedge inClock);
            inEnable = 1'b1;
            wait_done(d0 + 1, SYM_CYC + 100, "table");
            inEnable = 1'b0;
            got = '0; got_iq = '0;
            for (int i = 0; i < 32; i++)
                if (b + i < chips.size()) begin
                    got[31 - i]    = chips[b + i];
                    got_iq[31 - i] = iqs[b + i];
                end
            check($sformatf("table sym %0h chips", tbl[t].sym), got, tbl[t].chips);
            check("table iq pattern", got_iq, 32'h55555555);
            check("table pops", pop_cnt - p0, 1);
            check("table underrun", under_cnt - u0, 1);
            check("table valid low after", {31'd0, outChipValid}, 0);
            check("table chip spacing", gap_err - g0, 0);
            check("table chip hold", hold_err - h0, 0);
        end

        // empty FIFO with enable: nothing happens
        p0 = pop_cnt; v0 = valid_cnt; u0 = under_cnt;
        inEnable = 1'b1;
        repeat (200) @(negedge inClock);
        inEnable = 1'b0;
        check("empty pops", pop_cnt - p0, 0);
        check("empty valid", valid_cnt - v0, 0);
        check("empty underrun", under_cnt - u0, 0);

        // 15 back-to-back symbols
        exp_syms.delete();
        for (int i = 1; i < 16; i++) begin
            exp_syms.push_back(4'(i));
            fifo.push_back(4'(i));
        end
        b = chips.size(); d0 = done_cnt; u0 = under_cnt; p0 = pop_cnt; g0 = gap_err; h0 = hold_err;
        @(negedge inClock);
        inEnable = 1'b1;
        wait_done(d0 + 15, 15 * SYM_CYC + 200, "burst");
        inEnable = 1'b0;
        check_stream("burst", b);
        check("burst pops", pop_cnt - p0, 15);
        check("burst underrun", under_cnt - u0, 1);
        check("burst gapless", gap_err - g0, 0);
        check("burst chip hold", hold_err - h0, 0);

        // enable dropped mid-symbol with the next symbol already prefetched
        exp_syms.delete();
        exp_syms.push_back(4'h3);
        exp_syms.push_back(4'h4);
        fifo.push_back(4'h3); fifo.push_back(4'h4); fifo.push_back(4'h6);
        b = chips.size(); d0 = done_cnt; u0 = under_cnt; p0 = pop_cnt; s0 = strobe_cnt;
        @(negedge inClock);
        inEnable = 1'b1;
        wait_strobes(s0 + 11, "enable drop");
        inEnable = 1'b0;
        wait_done(d0 + 2, 2 * SYM_CYC + 100, "enable drop");
        repeat (50) @(negedge inClock);
        check_stream("enable drop", b);
        check("enable drop pops", pop_cnt - p0, 2);
        check("enable drop underrun", under_cnt - u0, 0);
        check("enable drop fifo left", fifo.size(), 1);
        fifo.delete();
        @(negedge inClock);

        // asynchronous reset in the middle of a symbol, then a clean restart
        fifo.push_back(4'h7);
        s0 = strobe_cnt;
        @(negedge inClock);
        inEnable = 1'b1;
        wait_strobes(s0 + 18, "reset");
        #3 inReset = 1'b1;
        #1 check("async reset outputs", {25'd0, outFifoReadEnable, outChip, outChipStrobe, outChipIQ,
                                         outChipValid, outSymbolDone, outUnderrun}, 32'd0);
        inEnable = 1'b0;
        repeat (2) @(negedge inClock);
        inReset = 1'b0;
        @(negedge inClock);
        exp_syms.delete();
        exp_syms.push_back(4'h5);
        fifo.push_back(4'h5);
        b = chips.size(); d0 = done_cnt;
        @(negedge inClock);
        inEnable = 1'b1;
        wait_done(d0 + 1, SYM_CYC + 100, "after reset");
        inEnable = 1'b0;
        check_stream("after reset", b);

        // random symbol streams against the model
        exp_syms.delete();
        for (int i = 0; i < 8; i++) begin
            exp_syms.push_back(4'($urandom_range(0, 15)));
            fifo.push_back(exp_syms[i]);
        end
        b = chips.size(); d0 = done_cnt; u0 = under_cnt; p0 = pop_cnt; g0 = gap_err;
        @(negedge inClock);
        inEnable = 1'b1;
        wait_done(d0 + 8, 8 * SYM_CYC + 200, "random");
        inEnable = 1'b0;
        check_stream("random", b);
        check("random pops", pop_cnt - p0, 8);
        check("random underrun", under_cnt - u0, 1);
        check("random gapless", gap_err - g0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
